// File: rtl/lpc_pkg.sv
// Shared LPC target definitions: FSM state encoding and LAD nibble codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lpc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CYCTYPE,
        ST_ADDR,
        ST_WDATA,
        ST_HTAR,
        ST_SYNC,
        ST_RDATA,
        ST_TTAR
    } lpc_state_e;

    // CYCTYPE/DIR nibble values for I/O cycles; bit 1 carries the direction.
    localparam logic [3:0] IO_RD      = 4'b0000;
    localparam logic [3:0] IO_WR      = 4'b0010;

    // Nibbles driven or recognised on LAD.
    localparam logic [3:0] SYNC_READY = 4'b0000;
    localparam logic [3:0] TAR_DRIVE  = 4'b1111;
    localparam logic [3:0] START      = 4'b0000;

endpackage

// File: rtl/lpc_io_target.sv
// LPC I/O target: decodes host I/O read/write cycles, strobes the register bank, returns read data.
// Latency: Wr in c10 of a write, Rd in c8 of a read; read data on LAD in c9/c10; LAD released in c12.
// Backpressure: none; always answers with a ready SYNC, LFRAME_N low aborts/restarts at any clock.
//
// Ports:
//   LpcClock, PciReset      33 MHz LPC clock, async active-low reset
//   LFRAME_N, LAD_in        host frame and sampled LAD pins
//   LAD_out, LAD_oe         target drive value and enable for LAD
//   RdData                  register value at Addr (combinational from the bank)
//   Addr, Wr, Rd, DataWrSW  register-bank strobe interface (all registered)
module lpc_io_target
    import lpc_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h0800,
    parameter int unsigned ADDR_BITS = 5
) (
    input  logic       LpcClock,
    input  logic       PciReset,
    input  logic       LFRAME_N,
    input  logic [3:0] LAD_in,
    output logic [3:0] LAD_out,
    output logic       LAD_oe,
    input  logic [7:0] RdData,
    output logic [7:0] Addr,
    output logic       Wr,
    output logic       Rd,
    output logic [7:0] DataWrSW
);

    lpc_state_e  state_q,   state_d;
    logic [1:0]  cnt_q,     cnt_d;
    logic        dir_wr_q,  dir_wr_d;
    // Only the first three address nibbles need storing; the fourth is
    // decoded straight off LAD in the last address clock.
    logic [11:0] io_addr_q, io_addr_d;
    logic [7:0]  addr_q,    addr_d;
    logic [7:0]  data_q,    data_d;
    // Low read nibble goes out directly from RdData; only the high one waits.
    logic [3:0]  rdata_hi_q, rdata_hi_d;
    logic [3:0]  lad_out_q, lad_out_d;
    logic        lad_oe_q,  lad_oe_d;
    logic        wr_q,      wr_d;
    logic        rd_q,      rd_d;

    logic [15:0] full_addr;
    logic        addr_hit;

    assign full_addr = {io_addr_q, LAD_in};
    assign addr_hit  = (full_addr[15:ADDR_BITS] == BASE_ADDR[15:ADDR_BITS]);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dir_wr_d   = dir_wr_q;
        io_addr_d  = io_addr_q;
        addr_d     = addr_q;
        data_d     = data_q;
        rdata_hi_d = rdata_hi_q;
        lad_out_d  = TAR_DRIVE;
        lad_oe_d   = 1'b0;
        wr_d       = 1'b0;
        rd_d       = 1'b0;

        if (!LFRAME_N) begin
            // Frame low wins over everything: restart on START, else drop out.
            // Drive and strobes fall back to their defaults on this edge.
            state_d = (LAD_in == START) ? ST_CYCTYPE : ST_IDLE;
            cnt_d   = 2'd0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                end
                ST_CYCTYPE: begin
                    if (LAD_in[3:2] == IO_RD[3:2]) begin
                        state_d  = ST_ADDR;
                        cnt_d    = 2'd0;
                        dir_wr_d = (LAD_in[1] == IO_WR[1]);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ADDR: begin
                    io_addr_d = full_addr[11:0];
                    cnt_d     = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        cnt_d = 2'd0;
                        if (addr_hit) begin
                            addr_d  = 8'(full_addr[ADDR_BITS-1:0]);
                            state_d = dir_wr_q ? ST_WDATA : ST_HTAR;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_WDATA: begin
                    if (cnt_q == 2'd0) begin
                        data_d[3:0] = LAD_in;
                        cnt_d       = 2'd1;
                    end else begin
                        data_d[7:4] = LAD_in;
                        cnt_d       = 2'd0;
                        state_d     = ST_HTAR;
                    end
                end
                ST_HTAR: begin
                    if (cnt_q == 2'd0) begin
                        cnt_d = 2'd1;
                    end else begin
                        // Outputs are registered, so SYNC and the strobe are
                        // set up on the edge that enters ST_SYNC.
                        cnt_d     = 2'd0;
                        state_d   = ST_SYNC;
                        lad_out_d = SYNC_READY;
                        lad_oe_d  = 1'b1;
                        wr_d      = dir_wr_q;
                        rd_d      = !dir_wr_q;
                    end
                end
                ST_SYNC: begin
                    lad_oe_d = 1'b1;
                    if (dir_wr_q) begin
                        state_d = ST_TTAR;
                    end else begin
                        // Sampled on the same edge the bank acts on Rd, so the
                        // value before any read side effect is returned.
                        lad_out_d  = RdData[3:0];
                        rdata_hi_d = RdData[7:4];
                        cnt_d      = 2'd0;
                        state_d    = ST_RDATA;
                    end
                end
                ST_RDATA: begin
                    lad_oe_d = 1'b1;
                    if (cnt_q == 2'd0) begin
                        lad_out_d = rdata_hi_q;
                        cnt_d     = 2'd1;
                    end else begin
                        cnt_d   = 2'd0;
                        state_d = ST_TTAR;
                    end
                end
                ST_TTAR: begin
                    // The 1111 clock is already on LAD; release on this edge.
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge LpcClock or negedge PciReset) begin
        if (!PciReset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 2'd0;
            dir_wr_q   <= 1'b0;
            io_addr_q  <= 12'd0;
            addr_q     <= 8'd0;
            data_q     <= 8'd0;
            rdata_hi_q <= 4'd0;
            lad_out_q  <= TAR_DRIVE;
            lad_oe_q   <= 1'b0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dir_wr_q   <= dir_wr_d;
            io_addr_q  <= io_addr_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rdata_hi_q <= rdata_hi_d;
            lad_out_q  <= lad_out_d;
            lad_oe_q   <= lad_oe_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
        end
    end

    assign LAD_out  = lad_out_q;
    assign LAD_oe   = lad_oe_q;
    assign Addr     = addr_q;
    assign Wr       = wr_q;
    assign Rd       = rd_q;
    assign DataWrSW = data_q;

endmodule

// File: tb/tb_lpc_io_target.sv
// Directed bench for lpc_io_target with a small register-bank model behind it.
// Each LPC clock: inputs driven 1 ns after posedge, outputs recorded at negedge.
// Bank model: Addr 0x0B clears bit 6 on Rd.
module tb_lpc_io_target;

    logic       LpcClock;
    logic       PciReset;
    logic       LFRAME_N;
    logic [3:0] LAD_in;
    logic [3:0] LAD_out;
    logic       LAD_oe;
    logic [7:0] RdData;
    logic [7:0] Addr;
    logic       Wr;
    logic       Rd;
    logic [7:0] DataWrSW;

    lpc_io_target #(
        .BASE_ADDR (16'h0800),
        .ADDR_BITS (5)
    ) dut (
        .LpcClock (LpcClock),
        .PciReset (PciReset),
        .LFRAME_N (LFRAME_N),
        .LAD_in   (LAD_in),
        .LAD_out  (LAD_out),
        .LAD_oe   (LAD_oe),
        .RdData   (RdData),
        .Addr     (Addr),
        .Wr       (Wr),
        .Rd       (Rd),
        .DataWrSW (DataWrSW)
    );

    initial LpcClock = 1'b0;
    always #15 LpcClock = ~LpcClock;

    // Register bank model
    logic [7:0] bank [0:31];
    logic       pl_vld;
    logic [4:0] pl_idx;
    logic [7:0] pl_val;

    assign RdData = bank[Addr[4:0]];

    always @(posedge LpcClock) begin
        if (pl_vld) begin
            bank[pl_idx] <= pl_val;
        end else begin
            if (Wr) bank[Addr[4:0]] <= DataWrSW;
            if (Rd && Addr == 8'h0B) bank[5'h0B] <= bank[5'h0B] & ~8'h40;
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Host stimulus per clock, and recorded target outputs per clock
    logic       h_frm [0:15];
    logic [3:0] h_lad [0:15];
    logic       o_oe  [0:15];
    logic [3:0] o_out [0:15];
    logic       o_wr  [0:15];
    logic       o_rd  [0:15];
    logic [7:0] o_addr[0:15];
    logic [7:0] o_data[0:15];
    int wr_sum, rd_sum, oe_sum, both_sum;

    task automatic build(input logic [3:0] cyc, input logic [15:0] a, input logic [7:0] d, input logic is_wr);
        for (int i = 0; i < 16; i++) begin
            h_frm[i] = 1'b1;
            h_lad[i] = 4'hF;
        end
        h_frm[0] = 1'b0;
        h_lad[0] = 4'h0;
        h_lad[1] = cyc;
        h_lad[2] = a[15:12];
        h_lad[3] = a[11:8];
        h_lad[4] = a[7:4];
        h_lad[5] = a[3:0];
        if (is_wr) begin
            h_lad[6] = d[3:0];
            h_lad[7] = d[7:4];
        end
    endtask

    task automatic run(input int n);
        wr_sum = 0; rd_sum = 0; oe_sum = 0; both_sum = 0;
        for (int i = 0; i < n; i++) begin
            LFRAME_N = h_frm[i];
            LAD_in   = h_lad[i];
            @(negedge LpcClock);
            o_oe[i]   = LAD_oe;
            o_out[i]  = LAD_out;
            o_wr[i]   = Wr;
            o_rd[i]   = Rd;
            o_addr[i] = Addr;
            o_data[i] = DataWrSW;
            wr_sum   += int'(Wr);
            rd_sum   += int'(Rd);
            oe_sum   += int'(LAD_oe);
            both_sum += int'(Wr & Rd);
            @(posedge LpcClock);
            #1;
        end
        LFRAME_N = 1'b1;
        LAD_in   = 4'hF;
    endtask

    task automatic preload(input logic [4:0] idx, input logic [7:0] val);
        pl_vld = 1'b1;
        pl_idx = idx;
        pl_val = val;
        @(posedge LpcClock);
        #1;
        pl_vld = 1'b0;
    endtask

    initial begin
        PciReset = 1'b0;
        LFRAME_N = 1'b1;
        LAD_in   = 4'hF;
        pl_vld   = 1'b0;
        pl_idx   = 5'd0;
        pl_val   = 8'd0;

        // Reset state
        repeat (2) @(posedge LpcClock);
        #1;
        check("rst_oe",   LAD_oe,   1'b0);
        check("rst_out",  LAD_out,  4'hF);
        check("rst_wr",   Wr,       1'b0);
        check("rst_rd",   Rd,       1'b0);
        check("rst_addr", Addr,     8'h00);
        check("rst_data", DataWrSW, 8'h00);
        PciReset = 1'b1;
        @(posedge LpcClock);
        #1;

        // I/O write 0x0808 <- 0x5A
        build(4'b0010, 16'h0808, 8'h5A, 1'b1);
        run(13);
        check("wr_strobe_c10", o_wr[10],   1'b1);
        check("wr_count",      wr_sum,     16'd1);
        check("wr_no_rd",      rd_sum,     16'd0);
        check("wr_addr",       o_addr[10], 8'h08);
        check("wr_data",       o_data[10], 8'h5A);
        check("wr_c9_oe",      o_oe[9],    1'b0);
        check("wr_sync_lad",   o_out[10],  4'h0);
        check("wr_sync_oe",    o_oe[10],   1'b1);
        check("wr_c11_lad",    o_out[11],  4'hF);
        check("wr_c11_oe",     o_oe[11],   1'b1);
        check("wr_c12_oe",     o_oe[12],   1'b0);
        check("wr_bank",       bank[5'h08], 8'h5A);

        // I/O read 0x0800 -> 0x3C
        preload(5'h00, 8'h3C);
        build(4'b0000, 16'h0800, 8'h00, 1'b0);
        run(13);
        check("rd_c7_oe",      o_oe[7],   1'b0);
        check("rd_strobe_c8",  o_rd[8],   1'b1);
        check("rd_count",      rd_sum,    16'd1);
        check("rd_no_wr",      wr_sum,    16'd0);
        check("rd_addr",       o_addr[8], 8'h00);
        check("rd_sync_lad",   o_out[8],  4'h0);
        check("rd_sync_oe",    o_oe[8],   1'b1);
        check("rd_lo",         o_out[9],  4'hC);
        check("rd_hi",         o_out[10], 4'h3);
        check("rd_c11_lad",    o_out[11], 4'hF);
        check("rd_c11_oe",     o_oe[11],  1'b1);
        check("rd_c12_oe",     o_oe[12],  1'b0);

        // Read-clear register: host must see the value before the clear
        preload(5'h0B, 8'h60);
        build(4'b0000, 16'h080B, 8'h00, 1'b0);
        run(13);
        check("rc_lo",         o_out[9],    4'h0);
        check("rc_hi",         o_out[10],   4'h6);
        check("rc_addr",       o_addr[8],   8'h0B);
        check("rc_bank_after", bank[5'h0B], 8'h20);

        // Address miss (write to 0x0900)
        build(4'b0010, 16'h0900, 8'hEE, 1'b1);
        run(13);
        check("miss_oe",   oe_sum,      16'd0);
        check("miss_wr",   wr_sum,      16'd0);
        check("miss_rd",   rd_sum,      16'd0);
        check("miss_addr", o_addr[12],  8'h0B);
        check("miss_bank", bank[5'h00], 8'h3C);

        // Memory cycle type is ignored
        build(4'b0100, 16'h0808, 8'h00, 1'b0);
        run(13);
        check("mem_oe", oe_sum, 16'd0);
        check("mem_wr", wr_sum, 16'd0);
        check("mem_rd", rd_sum, 16'd0);

        // Abort at c4 of a write
        build(4'b0010, 16'h0808, 8'h11, 1'b1);
        h_frm[4] = 1'b0;
        h_lad[4] = 4'hF;
        run(13);
        check("abw_wr",   wr_sum,      16'd0);
        check("abw_oe",   oe_sum,      16'd0);
        check("abw_bank", bank[5'h08], 8'h5A);

        // Abort at c9 of a read (target driving data)
        build(4'b0000, 16'h0800, 8'h00, 1'b0);
        h_frm[9] = 1'b0;
        h_lad[9] = 4'hF;
        run(13);
        check("abr_rd",     rd_sum,   16'd1);
        check("abr_c9_oe",  o_oe[9],  1'b1);
        check("abr_c9_lad", o_out[9], 4'hC);
        check("abr_c10_oe", o_oe[10], 1'b0);
        check("abr_c11_oe", o_oe[11], 1'b0);

        // Reset during c10 of a write
        build(4'b0010, 16'h0808, 8'h77, 1'b1);
        run(10);
        check("prst_wr", Wr, 1'b1);
        PciReset = 1'b0;
        #1;
        check("arst_oe",  LAD_oe,   1'b0);
        check("arst_lad", LAD_out,  4'hF);
        check("arst_wr",  Wr,       1'b0);
        check("arst_addr", Addr,    8'h00);
        @(posedge LpcClock);
        #1;
        PciReset = 1'b1;
        check("arst_bank", bank[5'h08], 8'h5A);

        // Two back-to-back writes: second START shares c12 of the first
        build(4'b0010, 16'h0810, 8'hA5, 1'b1);
        run(12);
        check("b2b1_wr",   wr_sum,     16'd1);
        check("b2b1_addr", o_addr[10], 8'h10);
        check("b2b1_data", o_data[10], 8'hA5);
        build(4'b0010, 16'h081F, 8'h3C, 1'b1);
        run(13);
        check("b2b2_c0_oe", o_oe[0],    1'b0);
        check("b2b2_wr",    wr_sum,     16'd1);
        check("b2b2_strb",  o_wr[10],   1'b1);
        check("b2b2_addr",  o_addr[10], 8'h1F);
        check("b2b2_data",  o_data[10], 8'h3C);
        check("b2b2_both",  both_sum,   16'd0);
        check("b2b_bank1",  bank[5'h10], 8'hA5);
        check("b2b_bank2",  bank[5'h1F], 8'h3C);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
